// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/memory) arbiter onto a single-beat shared memory bus
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // fetch-stage read port
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic [2:0]  ireq_size,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  // memory-stage read/write port
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_wdata,
  input  logic        dreq_write,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  // shared memory bus
  output logic        creq_valid,
  output logic        creq_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_wdata,
  input  logic        cresp_ready,
  input  logic [63:0] cresp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // last_grant encoding: reset value is GRANT_I so the memory stage wins the first tie
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        req_write_q, req_write_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [2:0]  req_size_q, req_size_d;
  logic [7:0]  req_strobe_q, req_strobe_d;
  logic [63:0] req_wdata_q, req_wdata_d;

  logic        grant_d_win;
  logic        i_done;
  logic        d_done;

  // Round-robin pick: D wins when alone, or on a tie when I was served last
  always_comb begin
    grant_d_win = 1'b0;
    if (dreq_valid && (!ireq_valid || (last_grant_q == GRANT_I))) begin
      grant_d_win = 1'b1;
    end
  end

  // A completion is only honoured while a transaction is owned; cresp_ready in IDLE is ignored
  always_comb begin
    i_done = 1'b0;
    d_done = 1'b0;
    if (cresp_ready) begin
      i_done = (state_q == BUSY_I);
      d_done = (state_q == BUSY_D);
    end
  end

  // Next-state and request-latch computation; request registers only change on a grant
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_size_d   = req_size_q;
    req_strobe_d = req_strobe_q;
    req_wdata_d  = req_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_d_win) begin
          state_d      = BUSY_D;
          req_write_d  = dreq_write;
          req_addr_d   = dreq_addr;
          req_size_d   = dreq_size;
          req_strobe_d = dreq_strobe;
          req_wdata_d  = dreq_wdata;
        end else if (ireq_valid) begin
          // fetches are always reads: no write, no byte enables, no write data
          state_d      = BUSY_I;
          req_write_d  = 1'b0;
          req_addr_d   = ireq_addr;
          req_size_d   = ireq_size;
          req_strobe_d = 8'h00;
          req_wdata_d  = 64'h0;
        end
      end
      BUSY_I: begin
        // a dropped ireq_valid (flush) does not abort: wait for the bus to complete
        if (i_done) begin
          state_d      = IDLE;
          last_grant_d = GRANT_I;
        end
      end
      BUSY_D: begin
        if (d_done) begin
          state_d      = IDLE;
          last_grant_d = GRANT_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and request registers; reset wins over any in-flight transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      req_write_q  <= 1'b0;
      req_addr_q   <= 64'h0;
      req_size_q   <= 3'd0;
      req_strobe_q <= 8'h00;
      req_wdata_q  <= 64'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_size_q   <= req_size_d;
      req_strobe_q <= req_strobe_d;
      req_wdata_q  <= req_wdata_d;
    end
  end

  // Bus request comes purely from registered state, so requester inputs cannot glitch it
  assign creq_valid  = (state_q != IDLE);
  assign creq_write  = req_write_q;
  assign creq_addr   = req_addr_q;
  assign creq_size   = req_size_q;
  assign creq_strobe = req_strobe_q;
  assign creq_wdata  = req_wdata_q;
  assign busy        = (state_q != IDLE);

  // Responses are forwarded in the completion cycle and forced to zero otherwise
  assign iresp_data_ok = i_done;
  assign dresp_data_ok = d_done;
  assign iresp_data    = i_done ? cresp_data : 64'h0;
  assign dresp_data    = d_done ? cresp_data : 64'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic [2:0]  ireq_size;
  logic        iresp_data_ok;
  logic [63:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dreq_write;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_wdata;
  logic        cresp_ready;
  logic [63:0] cresp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_size     (ireq_size),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_wdata    (dreq_wdata),
    .dreq_write    (dreq_write),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .creq_valid    (creq_valid),
    .creq_write    (creq_write),
    .creq_addr     (creq_addr),
    .creq_size     (creq_size),
    .creq_strobe   (creq_strobe),
    .creq_wdata    (creq_wdata),
    .cresp_ready   (cresp_ready),
    .cresp_data    (cresp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one row = inputs held for a cycle + outputs expected within that cycle
  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] ia;
    logic [2:0]  iz;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  dz;
    logic        dw;
    logic [7:0]  ds;
    logic [63:0] dwd;
    logic        cr;
    logic [63:0] cd;
    logic        cv;
    logic [63:0] ca;
    logic [2:0]  cz;
    logic        cw;
    logic [7:0]  cs;
    logic [63:0] cwd;
    logic        iok;
    logic [63:0] idat;
    logic        dok;
    logic [63:0] ddat;
    logic        bsy;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst;
    ireq_valid  = v.iv;
    ireq_addr   = v.ia;
    ireq_size   = v.iz;
    dreq_valid  = v.dv;
    dreq_addr   = v.da;
    dreq_size   = v.dz;
    dreq_write  = v.dw;
    dreq_strobe = v.ds;
    dreq_wdata  = v.dwd;
    cresp_ready = v.cr;
    cresp_data  = v.cd;
  endtask

  task automatic check_vec(input vec_t v, input int row);
    chk("creq_valid",    row, 64'(creq_valid),    64'(v.cv));
    chk("creq_addr",     row, creq_addr,          v.ca);
    chk("creq_size",     row, 64'(creq_size),     64'(v.cz));
    chk("creq_write",    row, 64'(creq_write),    64'(v.cw));
    chk("creq_strobe",   row, 64'(creq_strobe),   64'(v.cs));
    chk("creq_wdata",    row, creq_wdata,         v.cwd);
    chk("iresp_data_ok", row, 64'(iresp_data_ok), 64'(v.iok));
    chk("iresp_data",    row, iresp_data,         v.idat);
    chk("dresp_data_ok", row, 64'(dresp_data_ok), 64'(v.dok));
    chk("dresp_data",    row, dresp_data,         v.ddat);
    chk("busy",          row, 64'(busy),          64'(v.bsy));
  endtask

  initial begin
    //          rst   iv    ia                 iz    dv    da          dz    dw    ds     dwd                cr    cd          | cv    ca                 cz    cw    cs     cwd                iok   idat        dok   ddat        busy
    // quiet IDLE after reset
    vecs[0]  = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,            3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    // lone fetch at 0x8000_0000, ready two cycles after grant, then stray ready in IDLE
    vecs[1]  = '{1'b0, 1'b1, 64'h8000_0000,    3'd2, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,            3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[2]  = '{1'b0, 1'b1, 64'h8000_0000,    3'd2, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b1, 64'h8000_0000,    3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b1};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0000,    3'd2, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b1, 64'h13,     1'b1, 64'h8000_0000,    3'd2, 1'b0, 8'h00, 64'h0,            1'b1, 64'h13,     1'b0, 64'h0,      1'b1};
    vecs[4]  = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b1, 64'h55,     1'b0, 64'h8000_0000,    3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    // reset clears latched request; then simultaneous requests -> D first
    vecs[5]  = '{1'b1, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h8000_0000,    3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'h1000,         3'd2, 1'b1, 64'h2000,   3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,            3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'h1000,         3'd2, 1'b1, 64'h2000,   3'd3, 1'b0, 8'h00, 64'h0,            1'b1, 64'hD1,     1'b1, 64'h2000,         3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b1, 64'hD1,     1'b1};
    vecs[8]  = '{1'b0, 1'b1, 64'h1000,         3'd2, 1'b1, 64'h2008,   3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h2000,         3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[9]  = '{1'b0, 1'b1, 64'h1000,         3'd2, 1'b1, 64'h2008,   3'd3, 1'b0, 8'h00, 64'h0,            1'b1, 64'h11,     1'b1, 64'h1000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b1, 64'h11,     1'b0, 64'h0,      1'b1};
    // continuous contention keeps alternating D, I
    vecs[10] = '{1'b0, 1'b1, 64'h1004,         3'd2, 1'b1, 64'h2008,   3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h1000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[11] = '{1'b0, 1'b1, 64'h1004,         3'd2, 1'b1, 64'h2008,   3'd3, 1'b0, 8'h00, 64'h0,            1'b1, 64'h22,     1'b1, 64'h2008,         3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b1, 64'h22,     1'b1};
    vecs[12] = '{1'b0, 1'b1, 64'h1004,         3'd2, 1'b1, 64'h2010,   3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h2008,         3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[13] = '{1'b0, 1'b1, 64'h1004,         3'd2, 1'b1, 64'h2010,   3'd3, 1'b0, 8'h00, 64'h0,            1'b1, 64'h33,     1'b1, 64'h1004,         3'd2, 1'b0, 8'h00, 64'h0,            1'b1, 64'h33,     1'b0, 64'h0,      1'b1};
    // store latched, then inputs change mid-transaction and a fetch arrives
    vecs[14] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b1, 64'h100,    3'd2, 1'b1, 8'h0F, 64'hDEAD_BEEF,    1'b0, 64'h0,      1'b0, 64'h1004,         3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[15] = '{1'b0, 1'b1, 64'h3000,         3'd2, 1'b1, 64'h200,    3'd3, 1'b0, 8'hF0, 64'h0,            1'b0, 64'h0,      1'b1, 64'h100,          3'd2, 1'b1, 8'h0F, 64'hDEAD_BEEF,    1'b0, 64'h0,      1'b0, 64'h0,      1'b1};
    vecs[16] = '{1'b0, 1'b1, 64'h3000,         3'd2, 1'b1, 64'h200,    3'd3, 1'b0, 8'hF0, 64'h0,            1'b1, 64'h77,     1'b1, 64'h100,          3'd2, 1'b1, 8'h0F, 64'hDEAD_BEEF,    1'b0, 64'h0,      1'b1, 64'h77,     1'b1};
    // fetch granted, then flushed (valid dropped) while it owns the bus
    vecs[17] = '{1'b0, 1'b1, 64'h3000,         3'd2, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h100,          3'd2, 1'b1, 8'h0F, 64'hDEAD_BEEF,    1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[18] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b1, 64'h3000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b1};
    vecs[19] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b1, 64'h44,     1'b1, 64'h3000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b1, 64'h44,     1'b0, 64'h0,      1'b1};
    vecs[20] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h3000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    // reset while BUSY_D, ready arrives after the reset edge
    vecs[21] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b1, 64'h400,    3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h3000,         3'd2, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[22] = '{1'b1, 1'b0, 64'h0,            3'd0, 1'b1, 64'h400,    3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b1, 64'h400,          3'd3, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b1};
    vecs[23] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b1, 64'h99,     1'b0, 64'h0,            3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};
    vecs[24] = '{1'b0, 1'b0, 64'h0,            3'd0, 1'b0, 64'h0,      3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,            3'd0, 1'b0, 8'h00, 64'h0,            1'b0, 64'h0,      1'b0, 64'h0,      1'b0};

    reset       = 1'b1;
    ireq_valid  = 1'b0;
    ireq_addr   = 64'h0;
    ireq_size   = 3'd0;
    dreq_valid  = 1'b0;
    dreq_addr   = 64'h0;
    dreq_size   = 3'd0;
    dreq_strobe = 8'h00;
    dreq_wdata  = 64'h0;
    dreq_write  = 1'b0;
    cresp_ready = 1'b0;
    cresp_data  = 64'h0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < NVEC; r++) begin
      @(negedge clk);
      drive(vecs[r]);
      #1;
      check_vec(vecs[r], r);
    end

    // memory-stage load with a slow bus: grant within a bounded window, then a delayed completion
    begin
      int wait_cycles;
      bit granted;
      @(negedge clk);
      reset       = 1'b0;
      dreq_valid  = 1'b1;
      dreq_addr   = 64'h500;
      dreq_size   = 3'd3;
      dreq_write  = 1'b0;
      dreq_strobe = 8'h00;
      dreq_wdata  = 64'h0;
      cresp_ready = 1'b0;
      granted     = 1'b0;
      wait_cycles = 0;
      while (!granted && wait_cycles < 8) begin
        @(negedge clk);
        #1;
        wait_cycles++;
        if (creq_valid) granted = 1'b1;
      end
      chk("slow_grant", 100, 64'(granted), 64'h1);
      chk("slow_grant_latency", 100, 64'(wait_cycles), 64'd1);
      chk("slow_addr", 100, creq_addr, 64'h500);
      for (int k = 0; k < 3; k++) begin
        chk("slow_wait_dok", 101 + k, 64'(dresp_data_ok), 64'h0);
        chk("slow_wait_busy", 101 + k, 64'(busy), 64'h1);
        @(negedge clk);
        #1;
      end
      cresp_ready = 1'b1;
      cresp_data  = 64'hABCD;
      #1;
      chk("slow_dok", 104, 64'(dresp_data_ok), 64'h1);
      chk("slow_ddata", 104, dresp_data, 64'hABCD);
      chk("slow_iok", 104, 64'(iresp_data_ok), 64'h0);
      @(negedge clk);
      dreq_valid  = 1'b0;
      cresp_ready = 1'b0;
      cresp_data  = 64'h0;
      #1;
      chk("slow_after_dok", 105, 64'(dresp_data_ok), 64'h0);
      chk("slow_after_busy", 105, 64'(busy), 64'h0);
      chk("slow_after_cv", 105, 64'(creq_valid), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
